// File: rtl/mfp_irq_ctrl.sv
// mfp_irq_ctrl: MFP68901 interrupt controller.
// Collects 16 event strobes into pending bits, gates them with the enable and
// mask registers, resolves fixed priority (channel 15 highest), drives IRQ and
// returns {VR[7:4], channel} on acknowledge. "A" registers hold channels 15..8,
// "B" registers hold channels 7..0.
module mfp_irq_ctrl (
   input  logic        CLK,
   input  logic        RST,
   input  logic [15:0] EVT,
   input  logic [3:0]  REG_SEL,
   input  logic        WE,
   input  logic [7:0]  DI,
   output logic [7:0]  DO,
   input  logic        IACK,
   output logic        IRQ,
   output logic [7:0]  VEC,
   output logic        VEC_VALID
);

   localparam logic [3:0] SEL_IERA = 4'd0;
   localparam logic [3:0] SEL_IERB = 4'd1;
   localparam logic [3:0] SEL_IPRA = 4'd2;
   localparam logic [3:0] SEL_IPRB = 4'd3;
   localparam logic [3:0] SEL_ISRA = 4'd4;
   localparam logic [3:0] SEL_ISRB = 4'd5;
   localparam logic [3:0] SEL_IMRA = 4'd6;
   localparam logic [3:0] SEL_IMRB = 4'd7;
   localparam logic [3:0] SEL_VR   = 4'd8;

   logic [15:0] r_ier;
   logic [15:0] r_ipr;
   logic [15:0] r_isr;
   logic [15:0] r_imr;
   logic [3:0]  r_vr_base;
   logic        r_vr_s;
   logic [7:0]  r_vec;
   logic        r_vec_valid;

   logic [15:0] w_active;
   logic [3:0]  w_h;
   logic        w_blocked;
   logic        w_irq;
   logic        w_ack;
   logic [15:0] w_ier_nxt;
   logic [15:0] w_ipr_nxt;
   logic [15:0] w_isr_nxt;
   logic [15:0] w_imr_nxt;

   // Priority encoder: highest pending-and-unmasked channel wins.
   always_comb begin
      w_active = r_ipr & r_imr;
      w_h      = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (w_active[i]) w_h = 4'(i);
      end
   end

   // Request: in software-EOI mode an in-service channel at or above h blocks.
   always_comb begin
      w_blocked = |(r_isr & (16'hFFFF << w_h));
      w_irq     = (|w_active) && (!r_vr_s || !w_blocked);
      w_ack     = IACK && w_irq;
   end

   // Next register values; ordering of the updates encodes collision priority.
   always_comb begin
      w_ier_nxt = r_ier;
      w_imr_nxt = r_imr;
      w_ipr_nxt = r_ipr;
      w_isr_nxt = r_isr;

      if (WE && REG_SEL == SEL_IERA) w_ier_nxt[15:8] = DI;
      if (WE && REG_SEL == SEL_IERB) w_ier_nxt[7:0]  = DI;
      if (WE && REG_SEL == SEL_IMRA) w_imr_nxt[15:8] = DI;
      if (WE && REG_SEL == SEL_IMRB) w_imr_nxt[7:0]  = DI;

      // Pending: ack clear and software clear lose to a same-cycle event
      // (gated by the old enable), and a disable beats everything.
      if (w_ack) w_ipr_nxt[w_h] = 1'b0;
      if (WE && REG_SEL == SEL_IPRA) w_ipr_nxt[15:8] = w_ipr_nxt[15:8] & DI;
      if (WE && REG_SEL == SEL_IPRB) w_ipr_nxt[7:0]  = w_ipr_nxt[7:0]  & DI;
      w_ipr_nxt = w_ipr_nxt | (EVT & r_ier);
      w_ipr_nxt = w_ipr_nxt & w_ier_nxt;

      // In-service: software clears first, acknowledge (old S) sets last.
      if (WE && REG_SEL == SEL_ISRA) w_isr_nxt[15:8] = w_isr_nxt[15:8] & DI;
      if (WE && REG_SEL == SEL_ISRB) w_isr_nxt[7:0]  = w_isr_nxt[7:0]  & DI;
      if (WE && REG_SEL == SEL_VR && !DI[3]) w_isr_nxt = 16'h0000;
      if (w_ack && r_vr_s) w_isr_nxt[w_h] = 1'b1;
   end

   // Register state, vector capture and the one-cycle vector-valid pulse.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_ier       <= 16'h0000;
         r_ipr       <= 16'h0000;
         r_isr       <= 16'h0000;
         r_imr       <= 16'h0000;
         r_vr_base   <= 4'h0;
         r_vr_s      <= 1'b0;
         r_vec       <= 8'h00;
         r_vec_valid <= 1'b0;
      end else begin
         r_ier       <= w_ier_nxt;
         r_ipr       <= w_ipr_nxt;
         r_isr       <= w_isr_nxt;
         r_imr       <= w_imr_nxt;
         r_vec_valid <= w_ack;
         if (w_ack) r_vec <= {r_vr_base, w_h};
         if (WE && REG_SEL == SEL_VR) begin
            r_vr_base <= DI[7:4];
            r_vr_s    <= DI[3];
         end
      end
   end

   // Read-back mux; unused selects read as zero.
   always_comb begin
      DO = 8'h00;
      case (REG_SEL)
         SEL_IERA: DO = r_ier[15:8];
         SEL_IERB: DO = r_ier[7:0];
         SEL_IPRA: DO = r_ipr[15:8];
         SEL_IPRB: DO = r_ipr[7:0];
         SEL_ISRA: DO = r_isr[15:8];
         SEL_ISRB: DO = r_isr[7:0];
         SEL_IMRA: DO = r_imr[15:8];
         SEL_IMRB: DO = r_imr[7:0];
         SEL_VR:   DO = {r_vr_base, r_vr_s, 3'b000};
         default:  DO = 8'h00;
      endcase
   end

   assign IRQ       = w_irq;
   assign VEC       = r_vec;
   assign VEC_VALID = r_vec_valid;

endmodule

// File: tb/tb_mfp_irq_ctrl.sv
// Directed testbench for mfp_irq_ctrl.
module tb_mfp_irq_ctrl;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [15:0] EVT = 16'h0000;
   logic [3:0]  REG_SEL = 4'd0;
   logic        WE = 1'b0;
   logic [7:0]  DI = 8'h00;
   logic [7:0]  DO;
   logic        IACK = 1'b0;
   logic        IRQ;
   logic [7:0]  VEC;
   logic        VEC_VALID;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   mfp_irq_ctrl dut (
      .CLK       (CLK),
      .RST       (RST),
      .EVT       (EVT),
      .REG_SEL   (REG_SEL),
      .WE        (WE),
      .DI        (DI),
      .DO        (DO),
      .IACK      (IACK),
      .IRQ       (IRQ),
      .VEC       (VEC),
      .VEC_VALID (VEC_VALID)
   );

   always #50 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
      end
   endtask

   task automatic chk_reg(input string tag, input logic [3:0] sel, input logic [7:0] exp);
      REG_SEL = sel;
      #1;
      check(tag, DO, exp);
   endtask

   task automatic wr(input logic [3:0] sel, input logic [7:0] d);
      REG_SEL = sel;
      DI      = d;
      WE      = 1'b1;
      tick();
      WE      = 1'b0;
   endtask

   task automatic pulse(input logic [15:0] e);
      EVT = e;
      tick();
      EVT = 16'h0000;
   endtask

   task automatic ack();
      IACK = 1'b1;
      tick();
      IACK = 1'b0;
   endtask

   initial begin
      // Reset state
      RST = 1'b1;
      tick();
      tick();
      RST = 1'b0;
      for (int r = 0; r < 9; r++) chk_reg($sformatf("reset_reg%0d", r), 4'(r), 8'h00);
      chk_reg("reset_reg12", 4'd12, 8'h00);
      check("reset_irq", 8'(IRQ), 8'h00);
      check("reset_vec", VEC, 8'h00);
      check("reset_vv", 8'(VEC_VALID), 8'h00);

      // Basic single channel
      wr(4'd1, 8'h01);
      wr(4'd7, 8'h01);
      wr(4'd8, 8'h40);
      pulse(16'h0001);
      chk_reg("basic_iprb", 4'd3, 8'h01);
      check("basic_irq", 8'(IRQ), 8'h01);
      ack();
      check("basic_vec", VEC, 8'h40);
      check("basic_vv", 8'(VEC_VALID), 8'h01);
      chk_reg("basic_iprb_clr", 4'd3, 8'h00);
      check("basic_irq_low", 8'(IRQ), 8'h00);
      tick();
      check("basic_vv_drop", 8'(VEC_VALID), 8'h00);
      check("basic_vec_hold", VEC, 8'h40);

      // Priority, software EOI, IMR gating
      wr(4'd0, 8'h20);
      wr(4'd1, 8'h21);
      wr(4'd6, 8'h20);
      wr(4'd7, 8'h21);
      wr(4'd8, 8'h4F);
      chk_reg("vr_low_bits", 4'd8, 8'h48);
      pulse(16'h2020);
      chk_reg("prio_ipra", 4'd2, 8'h20);
      chk_reg("prio_iprb", 4'd3, 8'h20);
      check("prio_irq", 8'(IRQ), 8'h01);
      ack();
      check("prio_vec13", VEC, 8'h4D);
      chk_reg("prio_isra", 4'd4, 8'h20);
      chk_reg("prio_ipra_clr", 4'd2, 8'h00);
      check("prio_blocked", 8'(IRQ), 8'h00);
      wr(4'd4, 8'hDF);
      chk_reg("eoi_isra", 4'd4, 8'h00);
      check("eoi_irq", 8'(IRQ), 8'h01);
      ack();
      check("prio_vec5", VEC, 8'h45);
      chk_reg("prio_isrb", 4'd5, 8'h20);
      check("prio_irq_done", 8'(IRQ), 8'h00);
      wr(4'd6, 8'h00);
      pulse(16'h2000);
      chk_reg("mask_ipra", 4'd2, 8'h20);
      check("mask_irq", 8'(IRQ), 8'h00);

      // Nesting: higher channel pre-empts a channel in service
      wr(4'd6, 8'h20);
      check("unmask_irq", 8'(IRQ), 8'h01);
      ack();
      check("nest_vec13", VEC, 8'h4D);
      chk_reg("nest_isra13", 4'd4, 8'h20);
      check("nest_irq_low", 8'(IRQ), 8'h00);
      wr(4'd0, 8'h60);
      wr(4'd6, 8'h60);
      pulse(16'h4000);
      check("nest_irq14", 8'(IRQ), 8'h01);
      ack();
      check("nest_vec14", VEC, 8'h4E);
      chk_reg("nest_isra", 4'd4, 8'h60);
      wr(4'd8, 8'h40);
      chk_reg("vr_clr_isra", 4'd4, 8'h00);
      chk_reg("vr_clr_isrb", 4'd5, 8'h00);
      chk_reg("vr_read", 4'd8, 8'h40);

      // Disabled channel and IER-clears-IPR
      pulse(16'h0008);
      chk_reg("dis_iprb", 4'd3, 8'h00);
      check("dis_irq", 8'(IRQ), 8'h00);
      wr(4'd1, 8'h29);
      pulse(16'h0008);
      chk_reg("en_iprb", 4'd3, 8'h08);
      wr(4'd1, 8'h00);
      chk_reg("ierclr_iprb", 4'd3, 8'h00);
      chk_reg("ierclr_ierb", 4'd1, 8'h00);

      // Collisions on channel 0
      wr(4'd1, 8'h01);
      wr(4'd7, 8'h01);
      pulse(16'h0001);
      chk_reg("col_iprb_set", 4'd3, 8'h01);
      EVT = 16'h0001;
      wr(4'd3, 8'hFE);
      EVT = 16'h0000;
      chk_reg("col_evt_vs_iprw", 4'd3, 8'h01);
      wr(4'd3, 8'hFE);
      chk_reg("iprw_clears", 4'd3, 8'h00);
      pulse(16'h0001);
      check("col_irq_pre", 8'(IRQ), 8'h01);
      EVT = 16'h0001;
      ack();
      EVT = 16'h0000;
      chk_reg("col_evt_vs_ack", 4'd3, 8'h01);
      check("col_ack_irq", 8'(IRQ), 8'h01);
      check("col_ack_vec", VEC, 8'h40);
      check("col_ack_vv", 8'(VEC_VALID), 8'h01);
      EVT = 16'h0001;
      wr(4'd1, 8'h00);
      EVT = 16'h0000;
      chk_reg("col_disable_ipr", 4'd3, 8'h00);
      EVT = 16'h0001;
      wr(4'd1, 8'h01);
      EVT = 16'h0000;
      chk_reg("col_enable_ipr", 4'd3, 8'h00);
      chk_reg("col_enable_ier", 4'd1, 8'h01);

      // IACK without request, then reset after acknowledge
      wr(4'd8, 8'h80);
      ack();
      check("noirq_vv", 8'(VEC_VALID), 8'h00);
      check("noirq_vec", VEC, 8'h40);
      pulse(16'h0001);
      ack();
      check("vec80", VEC, 8'h80);
      check("vec80_vv", 8'(VEC_VALID), 8'h01);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("rst_vec", VEC, 8'h00);
      check("rst_vv", 8'(VEC_VALID), 8'h00);
      check("rst_irq", 8'(IRQ), 8'h00);

      // Acknowledge beats a same-cycle ISR clear
      wr(4'd1, 8'h01);
      wr(4'd7, 8'h01);
      wr(4'd8, 8'h48);
      pulse(16'h0001);
      IACK = 1'b1;
      wr(4'd5, 8'hFE);
      IACK = 1'b0;
      chk_reg("col_isr_ack", 4'd5, 8'h01);
      check("col_isr_vec", VEC, 8'h40);

      // Reset during acknowledge cancels it
      wr(4'd8, 8'h40);
      pulse(16'h0001);
      check("rstack_irq_pre", 8'(IRQ), 8'h01);
      IACK = 1'b1;
      RST  = 1'b1;
      tick();
      IACK = 1'b0;
      RST  = 1'b0;
      check("rstack_vv", 8'(VEC_VALID), 8'h00);
      check("rstack_vec", VEC, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mfp_irq_ctrl.md
# mfp_irq_ctrl

Interrupt controller for the MFP68901 model. It collects single-cycle event strobes from the four timers, the GPIP edge detectors and the USART, and keeps the enable, pending, in-service and mask registers. It resolves the fixed 16-level priority, drives the CPU interrupt request and returns the vector during the acknowledge cycle. It sits between the MFP's per-channel sources and the 68000 bus interface of the MFP top level.

## Interface
Parameters: none. Channel count is fixed at 16.
- CLK  in  1  system clock
- RST  in  1  reset; synchronous, active-high
- EVT  in  16  event strobes, one CLK wide; channel i = bit i (e.g. timer T_O_PULSE)
- REG_SEL  in  4  register select:
  - 0 IERA, 1 IERB, 2 IPRA, 3 IPRB, 4 ISRA, 5 ISRB, 6 IMRA, 7 IMRB, 8 VR
  - 9-15 read 0, writes ignored
- WE  in  1  register write strobe, one CLK
- DI  in  8  write data
- DO  out  8  read data; combinational from REG_SEL and the registers
- IACK  in  1  interrupt-acknowledge strobe, one CLK
- IRQ  out  1  interrupt request, active-high; the top level inverts it for the bus
- VEC  out  8  vector of the last accepted acknowledge
- VEC_VALID  out  1  one-CLK pulse when VEC is updated

## Operation
- Register mapping:
  - "A" registers bits 7..0 = channels 15..8; "B" registers bits 7..0 = channels 7..0.
  - Channel 15 has the highest priority, channel 0 the lowest.
- Enable (IER):
  - EVT[i] with IER[i]=1 sets IPR[i]. EVT[i] with IER[i]=0 is discarded.
  - Writing IER bit i to 0 also clears IPR[i].
- Pending (IPR) writes: DI bit 0 clears the pending bit; DI bit 1 leaves it unchanged. Software can never set IPR.
- In-service (ISR) writes: same rule as IPR (0 clears, 1 no effect).
- Mask (IMR) and VR: plain read/write.
  - VR[7:4] = vector base; VR[3] = S (software end-of-interrupt); VR[2:0] read as 0.
  - Writing VR with S=0 clears all 16 ISR bits.
- Active set = IPR & IMR. h = highest set index of the active set. IMR gates only IRQ; masked events still become pending.
- IRQ = (active set non-zero) AND (S=0 OR no ISR bit at index ≥ h).
  - A channel in service blocks requests of equal and lower priority.
- Acknowledge (IACK=1 while IRQ=1), same edge:
  - clear IPR[h];
  - if S=1, set ISR[h];
  - VEC <= {VR[7:4], h[3:0]};
  - VEC_VALID <= 1 for the next cycle only.
- IACK while IRQ=0: no state change, VEC holds, VEC_VALID stays 0.
- Simultaneous events, in priority order:
  - EVT[i] together with IACK clearing IPR[i]: the event wins, IPR[i] stays 1.
  - EVT[i] together with an IPR write clearing bit i: the event wins.
  - EVT[i] together with an IER write disabling channel i: IER takes the new value and IPR[i] is cleared. Disable wins.
  - EVT together with an IER write enabling channel i: the event is discarded. The old IER value applies.
  - IACK together with an ISR write clearing ISR[h] while S=1: ISR[h] ends set (acknowledge wins).
  - IACK together with any register write: the acknowledge uses pre-write register values.

## Timing
- Reset: every register is 0, IRQ=0, VEC=0x00, VEC_VALID=0, DO=0x00. RST during an acknowledge cancels it; VEC_VALID is 0 on the next cycle.
- A register write takes effect at the CLK edge where WE=1; DO reflects it from the next cycle.
- EVT at edge n → IPR set after edge n → IRQ high in cycle n+1 (combinational from registers).
- IACK sampled at edge m → VEC and VEC_VALID valid in cycle m+1. IRQ re-evaluates in cycle m+1 from the updated IPR/ISR.
- No internal state machine beyond the registers; back-to-back IACKs on consecutive cycles are legal and each is served.

## Test plan
- Reset, then read regs 0-8 → all 0x00, IRQ=0.
  - Write IERB=0x01, IMRB=0x01, VR=0x40; pulse EVT[0] → IPRB=0x01, IRQ=1 next cycle.
  - IACK → VEC=0x40, VEC_VALID one cycle, IPRB=0x00, IRQ=0.
- Priority and IMR gating:
  - Enable and unmask channels 13 and 5, VR=0x48 (S=1); pulse both in the same cycle.
  - IACK → VEC=0x4D, ISRA=0x20, IRQ=0 (channel 5 blocked by channel 13 in service).
  - Write ISRA=0xDF → IRQ=1; IACK → VEC=0x45.
  - With IMRA bit 5 masked, pulse channel 13 → IPRA=0x20, IRQ=0.
- Channel 13 in service (S=1); pulse channel 14 → IRQ=1; IACK → VEC=0x4E, ISRA=0x60.
  - Write VR=0x40 → ISRA=ISRB=0x00.
- Disabled channel: EVT[3] with IERB bit 3=0 → IPRB unchanged, IRQ=0.
  - Set IPRB bit 3, then write IERB=0x00 → IPRB bit 3 cleared.
- Collisions on channel 0:
  - EVT[0] in the same cycle as an IPRB=0xFE write → IPRB bit 0 = 1.
  - EVT[0] in the same cycle as an IACK that clears it → IPRB bit 0 = 1 and IRQ remains 1.
- IACK with IRQ=0 → VEC_VALID=0, VEC holds its old value.
  - RST asserted in the cycle after IACK → VEC=0x00, VEC_VALID=0.
